// File: rtl/spi_reg_pkg.sv
// Shared FSM states and constants for the SPI register bridge.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  localparam int unsigned CMD_RD_BIT      = 7;
  localparam logic [7:0]  IDLE_TX_DEFAULT = 8'h00;

endpackage

// File: rtl/spi_cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select with one-cycle edge pulses.
module spi_cs_sync (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_SPI_CS_n,
  output logic o_Rise,
  output logic o_Fall
);

  logic cs_meta;
  logic cs_sync;
  logic cs_prev;

  // Reset to the deasserted (high) level so leaving reset never fakes a frame end.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= i_SPI_CS_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign o_Rise = cs_sync & ~cs_prev;
  assign o_Fall = ~cs_sync & cs_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// Command decoder and register bank behind an SPI slave byte interface.
// Build option: SPI_REG_BRIDGE_AUTOINC_EN enables burst address auto-increment.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter logic [7:0]  IDLE_TX  = IDLE_TX_DEFAULT
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  input  logic                  i_SPI_CS_n,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  output logic                  o_Wr_Strobe,
  output logic [ADDR_W-1:0]     o_Wr_Addr,
  output logic [8*NUM_REGS-1:0] o_Regs
);

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        regs [NUM_REGS];
  logic [7:0]        rd_byte;
  logic [7:0]        tx_byte_d;
  logic              tx_dv_d;
  logic              wr_en_d;
  logic              cs_rise;
  logic              cs_fall_unused;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + ADDR_W'(1);
`else
    return a;
`endif
  endfunction

  spi_cs_sync u_cs_sync (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_SPI_CS_n (i_SPI_CS_n),
    .o_Rise     (cs_rise),
    .o_Fall     (cs_fall_unused)
  );

  // A read command returns its own start register, later reads use the running address.
  assign cmd_addr = i_RX_Byte[ADDR_W-1:0];
  assign rd_addr  = (state == IDLE) ? cmd_addr : addr;
  assign rd_byte  = in_range(rd_addr) ? regs[rd_addr] : 8'h00;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (i_RX_DV && (state == IDLE))
      state_d = i_RX_Byte[CMD_RD_BIT] ? RD_DATA : WR_DATA;
    if (cs_rise)
      state_d = IDLE;
  end

  // Frame end overrides any read load in the same cycle; a colliding write still lands.
  always_comb begin
    tx_dv_d   = 1'b0;
    tx_byte_d = o_TX_Byte;
    wr_en_d   = 1'b0;
    wr_addr_d = o_Wr_Addr;
    addr_d    = addr;
    if (i_RX_DV) begin
      case (state)
        IDLE: begin
          addr_d = cmd_addr;
          if (i_RX_Byte[CMD_RD_BIT]) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = rd_byte;
            addr_d    = next_addr(cmd_addr);
          end
        end
        WR_DATA: begin
          if (in_range(addr)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr;
          end
          addr_d = next_addr(addr);
        end
        RD_DATA: begin
          tx_dv_d   = 1'b1;
          tx_byte_d = rd_byte;
          addr_d    = next_addr(addr);
        end
        default: addr_d = addr;
      endcase
    end
    if (cs_rise) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = IDLE_TX;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      addr        <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= 8'h00;
      o_Wr_Strobe <= 1'b0;
      o_Wr_Addr   <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
    end else begin
      addr        <= addr_d;
      o_TX_DV     <= tx_dv_d;
      o_TX_Byte   <= tx_byte_d;
      o_Wr_Strobe <= wr_en_d;
      o_Wr_Addr   <= wr_addr_d;
      if (wr_en_d) regs[addr] <= i_RX_Byte;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign o_Regs[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Randomised scoreboard bench for spi_reg_bridge: a default instance and a 12-register, nonzero-IDLE_TX instance.
module tb_spi_reg_bridge;

  localparam int unsigned NA     = 16;
  localparam int unsigned NB     = 12;
  localparam logic [7:0]  IDLE_A = 8'h00;
  localparam logic [7:0]  IDLE_B = 8'hA5;

  typedef struct {
    logic [7:0]   data;
    logic [3:0]   addr;
    logic [127:0] regs;
    int unsigned  cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic         cs_n;
  logic         tx_dv_a, tx_dv_b;
  logic [7:0]   tx_byte_a, tx_byte_b;
  logic         wr_a, wr_b;
  logic [3:0]   wa_a, wa_b;
  logic [127:0] regs_a;
  logic [95:0]  regs_b;

  int unsigned  cyc = 0;
  int           errors = 0;
  int           checks = 0;

  exp_t txq_a[$];
  exp_t txq_b[$];
  exp_t wrq_a[$];
  exp_t wrq_b[$];

  logic [7:0]   m_regs [2][16];
  bit           m_first [2];
  bit           m_rd [2];
  int unsigned  m_addr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_bridge dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_SPI_CS_n(cs_n),
    .o_TX_DV(tx_dv_a), .o_TX_Byte(tx_byte_a), .o_Wr_Strobe(wr_a), .o_Wr_Addr(wa_a), .o_Regs(regs_a)
  );

  spi_reg_bridge #(.NUM_REGS(NB), .ADDR_W(4), .IDLE_TX(IDLE_B)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_SPI_CS_n(cs_n),
    .o_TX_DV(tx_dv_b), .o_TX_Byte(tx_byte_b), .o_Wr_Strobe(wr_b), .o_Wr_Addr(wa_b), .o_Regs(regs_b)
  );

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: byte-level frame semantics ----------------
  function automatic int unsigned nregs(input int i);
    return (i == 0) ? NA : NB;
  endfunction

  function automatic logic [7:0] m_val(input int i, input int unsigned a);
    return (a < nregs(i)) ? m_regs[i][a] : 8'h00;
  endfunction

  function automatic int unsigned m_adv(input int i, input int unsigned a);
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    return (a == nregs(i) - 1) ? 0 : (a + 1) % 16;
`else
    return (i >= 0) ? a : a;
`endif
  endfunction

  function automatic logic [127:0] m_snap(input int i);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = m_regs[i][k];
    return v;
  endfunction

  task automatic push_tx(input int i, input logic [7:0] d, input int unsigned c);
    exp_t e;
    e.data = d; e.addr = 4'h0; e.regs = '0; e.cyc = c;
    if (i == 0) txq_a.push_back(e); else txq_b.push_back(e);
  endtask

  task automatic push_wr(input int i, input logic [3:0] a, input int unsigned c);
    exp_t e;
    e.data = 8'h00; e.addr = a; e.regs = m_snap(i); e.cyc = c;
    if (i == 0) wrq_a.push_back(e); else wrq_b.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int unsigned c, input bit drop_tx);
    for (int i = 0; i < 2; i++) begin
      if (m_first[i]) begin
        m_first[i] = 1'b0;
        m_rd[i]    = b[7];
        m_addr[i]  = int'(b[3:0]);
        if (m_rd[i]) begin
          if (!drop_tx) push_tx(i, m_val(i, m_addr[i]), c);
          m_addr[i] = m_adv(i, m_addr[i]);
        end
      end else if (m_rd[i]) begin
        if (!drop_tx) push_tx(i, m_val(i, m_addr[i]), c);
        m_addr[i] = m_adv(i, m_addr[i]);
      end else begin
        if (m_addr[i] < nregs(i)) begin
          m_regs[i][m_addr[i]] = b;
          push_wr(i, 4'(m_addr[i]), c);
        end
        m_addr[i] = m_adv(i, m_addr[i]);
      end
    end
  endtask

  task automatic model_frame_end(input int unsigned c);
    push_tx(0, IDLE_A, c);
    push_tx(1, IDLE_B, c);
    m_first[0] = 1'b1;
    m_first[1] = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) m_regs[i][k] = 8'h00;
      m_first[i] = 1'b1;
      m_rd[i]    = 1'b0;
      m_addr[i]  = 0;
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int i, input logic tx_dv, input logic [7:0] tx_b,
                     input logic wr, input logic [3:0] wa, input logic [127:0] regs);
    exp_t  e;
    string s;
    s = (i == 0) ? "_a" : "_b";
    if (tx_dv) begin
      if ((i == 0) ? (txq_a.size() == 0) : (txq_b.size() == 0)) begin
        chk(1'b0, {"tx_unexpected", s}, 128'(tx_b), 128'(0));
      end else begin
        if (i == 0) e = txq_a.pop_front(); else e = txq_b.pop_front();
        chk(tx_b == e.data, {"tx_byte", s}, 128'(tx_b), 128'(e.data));
        chk(cyc == e.cyc, {"tx_cycle", s}, 128'(cyc), 128'(e.cyc));
      end
    end
    if (wr) begin
      if ((i == 0) ? (wrq_a.size() == 0) : (wrq_b.size() == 0)) begin
        chk(1'b0, {"wr_unexpected", s}, 128'(wa), 128'(0));
      end else begin
        if (i == 0) e = wrq_a.pop_front(); else e = wrq_b.pop_front();
        chk(wa == e.addr, {"wr_addr", s}, 128'(wa), 128'(e.addr));
        chk(regs == e.regs, {"wr_regs", s}, regs, e.regs);
        chk(cyc == e.cyc, {"wr_cycle", s}, 128'(cyc), 128'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, tx_dv_a, tx_byte_a, wr_a, wa_a, regs_a);
      mon(1, tx_dv_b, tx_byte_b, wr_b, wa_b, {32'h0, regs_b});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset();
    chk(regs_a == '0, "rst_regs_a", regs_a, 128'(0));
    chk(regs_b == '0, "rst_regs_b", 128'(regs_b), 128'(0));
    chk(!tx_dv_a && !tx_dv_b, "rst_tx_dv", 128'({tx_dv_a, tx_dv_b}), 128'(0));
    chk(tx_byte_a == 8'h00 && tx_byte_b == 8'h00, "rst_tx_byte", 128'({tx_byte_a, tx_byte_b}), 128'(0));
    chk(!wr_a && !wr_b, "rst_wr_strobe", 128'({wr_a, wr_b}), 128'(0));
    chk(wa_a == 4'h0 && wa_b == 4'h0, "rst_wr_addr", 128'({wa_a, wa_b}), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset();
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    idle(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    model_byte(b, cyc + 1, 1'b0);
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom);
    idle($urandom_range(1, 4));
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    model_frame_end(cyc + 3);
    idle(6);
  endtask

  // Last byte's strobe lands on the same clock that the synchronised rise is acted on.
  task automatic cs_high_collide(input logic [7:0] b);
    int unsigned c;
    @(negedge clk);
    cs_n = 1'b1;
    c    = cyc;
    idle(2);
    rx_dv   = 1'b1;
    rx_byte = b;
    model_byte(b, c + 3, 1'b1);
    model_frame_end(c + 3);
    @(negedge clk);
    rx_dv = 1'b0;
    idle(6);
  endtask

  initial begin
    int  nb;
    bit  col;
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    cs_n    = 1'b1;
    model_reset();
    idle(3);
    rst = 1'b0;
    check_reset();

    cs_low(); send_byte(8'h03); send_byte(8'h5A); cs_high();
    cs_low(); send_byte(8'h83); send_byte(8'hFF); cs_high();
    cs_low(); send_byte(8'h0F); send_byte(8'h11); send_byte(8'h22); cs_high();
    cs_low(); send_byte(8'h0D); send_byte(8'h77); cs_high();
    cs_low(); send_byte(8'h8D); send_byte(8'hFF); cs_high();
    cs_low(); send_byte(8'h05); cs_high_collide(8'h66);
    cs_low(); send_byte(8'h81); cs_high_collide(8'hFF);
    cs_low(); send_byte(8'h02); send_byte(8'h44); do_reset();
    send_byte(8'h81); send_byte(8'hFF); cs_high();

    for (int f = 0; f < 40; f++) begin
      nb  = $urandom_range(0, 4);
      col = ($urandom_range(0, 5) == 0);
      cs_low();
      send_byte(8'($urandom));
      if ($urandom_range(0, 15) == 0) do_reset();
      for (int k = 0; k < nb; k++) send_byte(8'($urandom));
      if (col) cs_high_collide(8'($urandom));
      else     cs_high();
    end

    idle(10);
    chk(txq_a.size() == 0, "txq_a_drained", 128'(txq_a.size()), 128'(0));
    chk(txq_b.size() == 0, "txq_b_drained", 128'(txq_b.size()), 128'(0));
    chk(wrq_a.size() == 0, "wrq_a_drained", 128'(wrq_a.size()), 128'(0));
    chk(wrq_b.size() == 0, "wrq_b_drained", 128'(wrq_b.size()), 128'(0));
    chk(regs_a == m_snap(0), "final_regs_a", regs_a, m_snap(0));
    chk({32'h0, regs_b} == m_snap(1), "final_regs_b", {32'h0, regs_b}, m_snap(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
